// File: rtl/btree_pkg.sv
// Shared widths, beat sideband layout and width helpers for the pipelined
// binary-tree adder.
package btree_pkg;
   localparam int SB_W    = 2;
   localparam int SB_ACC  = 1;
   localparam int SB_LAST = 0;

   function automatic int lvl_w(input int w, input int k);
      return w + k;
   endfunction

   function automatic int out_w(input int w, input int levels, input int acc_w);
      return w + levels + acc_w;
   endfunction

   // Bit offset of tree level k inside the flattened all-levels bus.
   function automatic int lvl_off(input int n_ops, input int w, input int k);
      int off;
      off = 0;
      for (int j = 0; j < k; j++) begin
         off = off + (n_ops >> j) * lvl_w(w, j);
      end
      return off;
   endfunction
endpackage

// File: rtl/btree_adder_pipe_level.sv
// One registered tree level: adds adjacent operand pairs and carries the beat
// sideband, loading whenever its register is empty or being drained.
module btree_level
   import btree_pkg::*;
#(
   parameter int PAIRS = 4,
   parameter int IW    = 16,
   localparam int OW   = IW + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [2*PAIRS*IW-1:0] in_data,
   input  logic                  in_cin,
   input  logic [SB_W-1:0]       in_sb,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [PAIRS*OW-1:0]   out_data,
   output logic [SB_W-1:0]       out_sb
);
   logic                valid_r;
   logic [PAIRS*OW-1:0] data_r;
   logic [SB_W-1:0]     sb_r;
   logic [PAIRS*OW-1:0] sum_s;
   logic                load_s;

   assign load_s    = !valid_r || out_ready;
   assign out_valid = valid_r;
   assign out_data  = data_r;
   assign out_sb    = sb_r;

   // Pairwise sums; the carry-in joins only the lowest pair so it is counted once.
   always_comb begin
      sum_s = '0;
      for (int p = 0; p < PAIRS; p++) begin
         sum_s[p*OW +: OW] = OW'(in_data[(2*p)*IW +: IW]) + OW'(in_data[(2*p+1)*IW +: IW]);
      end
      sum_s[OW-1:0] = sum_s[OW-1:0] + OW'(in_cin);
   end

   // Level register with collapsing-bubble valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r <= 1'b0;
         data_r  <= '0;
         sb_r    <= '0;
      end else if (load_s) begin
         valid_r <= in_valid;
         if (in_valid) begin
            data_r <= sum_s;
            sb_r   <= in_sb;
         end
      end
   end
endmodule

// File: rtl/btree_adder_pipe.sv
// Fully pipelined N_OPS-operand tree adder with valid/ready flow control,
// single carry-in, multi-beat accumulate mode and sticky overflow.
module btree_adder_pipe
   import btree_pkg::*;
#(
   parameter int  N_OPS  = 8,
   parameter int  W      = 16,
   parameter int  ACC_W  = 8,
   localparam int LEVELS = $clog2(N_OPS),
   localparam int OUT_W  = out_w(W, LEVELS, ACC_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N_OPS*W-1:0] in_ops,
   input  logic             in_cin,
   input  logic             in_acc,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_sum,
   output logic             out_ovf
);
   localparam int TW    = lvl_w(W, LEVELS);
   localparam int BUS_W = lvl_off(N_OPS, W, LEVELS + 1);

   // All level results side by side; level 0 is the raw operand vector.
   logic [BUS_W-1:0]  tree_s;
   logic [LEVELS:0]   lvl_valid_s;
   logic [LEVELS:0]   rdy_s;
   logic [SB_W-1:0]   lvl_sb_s [0:LEVELS];

   logic              out_valid_r;
   logic [OUT_W-1:0]  out_sum_r;
   logic              out_ovf_r;
   logic [OUT_W-1:0]  acc_r;
   logic              acc_active_r;
   logic              ovf_sticky_r;

   logic              adv_s;
   logic [TW-1:0]     tsum_s;
   logic              tree_acc_s;
   logic              tree_last_s;
   logic [OUT_W-1:0]  acc_base_s;
   logic [OUT_W:0]    acc_next_s;

   assign tree_s[N_OPS*W-1:0] = in_ops;
   assign lvl_valid_s[0]      = in_valid;
   assign lvl_sb_s[0]         = {in_acc, in_last};
   assign in_ready            = rdy_s[0];

   for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
      localparam int IW  = lvl_w(W, k - 1);
      localparam int NIN = N_OPS >> (k - 1);
      localparam int NO  = N_OPS >> k;
      btree_level #(
         .PAIRS (NO),
         .IW    (IW)
      ) u_level (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (lvl_valid_s[k-1]),
         .in_data   (tree_s[lvl_off(N_OPS, W, k - 1) +: NIN*IW]),
         .in_cin    ((k == 1) ? in_cin : 1'b0),
         .in_sb     (lvl_sb_s[k-1]),
         .out_valid (lvl_valid_s[k]),
         .out_ready (rdy_s[k]),
         .out_data  (tree_s[lvl_off(N_OPS, W, k) +: NO*(IW+1)]),
         .out_sb    (lvl_sb_s[k])
      );
   end

   assign adv_s       = !out_valid_r || out_ready;
   assign tsum_s      = tree_s[lvl_off(N_OPS, W, LEVELS) +: TW];
   assign tree_acc_s  = lvl_sb_s[LEVELS][SB_ACC];
   assign tree_last_s = lvl_sb_s[LEVELS][SB_LAST];

   // Ready chain resolved back from the output stage: ready_k = !v_k || ready_k+1.
   always_comb begin
      rdy_s         = '0;
      rdy_s[LEVELS] = adv_s;
      for (int j = LEVELS - 1; j >= 0; j--) begin
         rdy_s[j] = !lvl_valid_s[j+1] || rdy_s[j+1];
      end
   end

   // Running accumulation plus the tree result, with carry-out kept in the top bit.
   always_comb begin
      if (acc_active_r) begin
         acc_base_s = acc_r;
      end else begin
         acc_base_s = '0;
      end
      acc_next_s = {1'b0, acc_base_s} + (OUT_W+1)'(tsum_s);
   end

   // Output register and accumulator update.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r  <= 1'b0;
         out_sum_r    <= '0;
         out_ovf_r    <= 1'b0;
         acc_r        <= '0;
         acc_active_r <= 1'b0;
         ovf_sticky_r <= 1'b0;
      end else if (lvl_valid_s[LEVELS] && adv_s) begin
         if (!tree_acc_s) begin
            out_sum_r   <= OUT_W'(tsum_s);
            out_ovf_r   <= 1'b0;
            out_valid_r <= 1'b1;
         end else if (!tree_last_s) begin
            acc_r        <= acc_next_s[OUT_W-1:0];
            acc_active_r <= 1'b1;
            ovf_sticky_r <= ovf_sticky_r | acc_next_s[OUT_W];
            out_valid_r  <= 1'b0;
         end else begin
            out_sum_r    <= acc_next_s[OUT_W-1:0];
            out_ovf_r    <= ovf_sticky_r | acc_next_s[OUT_W];
            out_valid_r  <= 1'b1;
            acc_r        <= '0;
            acc_active_r <= 1'b0;
            ovf_sticky_r <= 1'b0;
         end
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign out_valid = out_valid_r;
   assign out_sum   = out_sum_r;
   assign out_ovf   = out_ovf_r;
endmodule

// File: tb/tb_btree_adder_pipe.sv
// Bench for btree_adder_pipe: two instances (ACC_W=8 and ACC_W=1) share one
// stimulus stream and are scored against a beat-level arithmetic model.
module tb_btree_adder_pipe;
   localparam int N    = 8;
   localparam int W    = 16;
   localparam int AW_A = 27;
   localparam int AW_B = 20;

   typedef struct {
      longint sum;
      bit     ovf;
   } res_t;

   logic clk = 1'b0;
   logic rst;
   logic in_valid, in_cin, in_acc, in_last, out_ready;
   logic [N*W-1:0] in_ops;
   logic a_in_ready, b_in_ready, a_out_valid, b_out_valid, a_out_ovf, b_out_ovf;
   logic [AW_A-1:0] a_out_sum;
   logic [AW_B-1:0] b_out_sum;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   res_t   exp_a[$], exp_b[$];
   longint acc_a, acc_b;
   bit     ovf_a, ovf_b;
   longint log_a[$], log_b[$];
   int     log_a_cyc[$];
   bit     log_b_ovf[$];
   bit     saw_stall;
   bit     a_hold, b_hold;
   longint a_hold_sum, b_hold_sum;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   btree_adder_pipe #(.N_OPS(N), .W(W), .ACC_W(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
      .in_ops(in_ops), .in_cin(in_cin), .in_acc(in_acc), .in_last(in_last),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_sum(a_out_sum), .out_ovf(a_out_ovf));

   btree_adder_pipe #(.N_OPS(N), .W(W), .ACC_W(1)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
      .in_ops(in_ops), .in_cin(in_cin), .in_acc(in_acc), .in_last(in_last),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_sum(b_out_sum), .out_ovf(b_out_ovf));

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [N*W-1:0] all_ops(input logic [W-1:0] v);
      logic [N*W-1:0] o;
      for (int i = 0; i < N; i++) o[i*W +: W] = v;
      return o;
   endfunction

   function automatic logic [N*W-1:0] ramp_ops(input int b);
      logic [N*W-1:0] o;
      for (int i = 0; i < N; i++) o[i*W +: W] = W'(b + i);
      return o;
   endfunction

   function automatic logic [N*W-1:0] rand_ops();
      logic [N*W-1:0] o;
      bit big;
      big = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) o[i*W +: W] = big ? 16'hFFFF : W'($urandom);
      return o;
   endfunction

   // Reference: a beat is the plain sum of its operands plus carry-in; results
   // are the beat itself or the modular accumulation closed by a last beat.
   task automatic model_beat(input logic [N*W-1:0] ops, input logic cin, input logic acc, input logic last);
      longint t;
      res_t   r;
      t = longint'(cin);
      for (int i = 0; i < N; i++) t += longint'(ops[i*W +: W]);
      if (!acc) begin
         r.sum = t; r.ovf = 1'b0;
         exp_a.push_back(r);
         exp_b.push_back(r);
      end else begin
         acc_a += t;
         if (acc_a >= (64'sd1 <<< AW_A)) begin acc_a -= (64'sd1 <<< AW_A); ovf_a = 1'b1; end
         acc_b += t;
         if (acc_b >= (64'sd1 <<< AW_B)) begin acc_b -= (64'sd1 <<< AW_B); ovf_b = 1'b1; end
         if (last) begin
            r.sum = acc_a; r.ovf = ovf_a; exp_a.push_back(r);
            r.sum = acc_b; r.ovf = ovf_b; exp_b.push_back(r);
            acc_a = 0; acc_b = 0; ovf_a = 1'b0; ovf_b = 1'b0;
         end
      end
   endtask

   // Compare process: scores every result as it is taken and checks hold under stall.
   initial begin
      res_t r;
      forever begin
         @(negedge clk);
         if (rst) begin
            exp_a.delete(); exp_b.delete();
            acc_a = 0; acc_b = 0; ovf_a = 1'b0; ovf_b = 1'b0;
            a_hold = 1'b0; b_hold = 1'b0;
         end else begin
            if (a_hold) begin
               chk("a_stall_valid", a_out_valid, 1);
               chk("a_stall_sum", a_out_sum, a_hold_sum);
            end
            if (b_hold) begin
               chk("b_stall_valid", b_out_valid, 1);
               chk("b_stall_sum", b_out_sum, b_hold_sum);
            end
            if (a_out_valid && out_ready) begin
               if (exp_a.size() == 0) chk("a_spurious_result", a_out_valid, 0);
               else begin
                  r = exp_a.pop_front();
                  chk("a_sum", a_out_sum, r.sum);
                  chk("a_ovf", a_out_ovf, r.ovf);
                  log_a.push_back(a_out_sum);
                  log_a_cyc.push_back(cyc);
               end
            end
            if (b_out_valid && out_ready) begin
               if (exp_b.size() == 0) chk("b_spurious_result", b_out_valid, 0);
               else begin
                  r = exp_b.pop_front();
                  chk("b_sum", b_out_sum, r.sum);
                  chk("b_ovf", b_out_ovf, r.ovf);
                  log_b.push_back(b_out_sum);
                  log_b_ovf.push_back(b_out_ovf);
               end
            end
            a_hold = a_out_valid && !out_ready; a_hold_sum = a_out_sum;
            b_hold = b_out_valid && !out_ready; b_hold_sum = b_out_sum;
            if (in_valid && a_in_ready) model_beat(in_ops, in_cin, in_acc, in_last);
            if (in_valid && !(a_in_ready && b_in_ready)) saw_stall = 1'b1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic idle();
      in_valid = 1'b0; in_acc = 1'b0; in_last = 1'b0; in_cin = 1'b0;
   endtask

   // Present one beat and hold it until accepted (bounded).
   task automatic send(input logic [N*W-1:0] ops, input logic cin, input logic acc, input logic last);
      bit done;
      done = 1'b0;
      in_valid = 1'b1; in_ops = ops; in_cin = cin; in_acc = acc; in_last = last;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         done = a_in_ready;
         @(posedge clk); #1;
      end
      if (!done) chk("accept_timeout", a_in_ready, 1);
   endtask

   task automatic drain(input int limit);
      int n;
      n = 0;
      while ((exp_a.size() != 0 || exp_b.size() != 0) && n < limit) begin tick(1); n++; end
      if (n >= limit) begin
         chk("drain_a_pending", exp_a.size(), 0);
         chk("drain_b_pending", exp_b.size(), 0);
      end
      tick(2);
   endtask

   task automatic clear_logs();
      log_a.delete(); log_a_cyc.delete(); log_b.delete(); log_b_ovf.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  lat;
      bit  got;
      bit  rdone;
      rst = 1'b1; in_valid = 1'b0; in_ops = '0; in_cin = 1'b0; in_acc = 1'b0; in_last = 1'b0;
      out_ready = 1'b1; saw_stall = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      chk("reset_a_in_ready", a_in_ready, 1);
      chk("reset_b_in_ready", b_in_ready, 1);
      chk("reset_a_out_valid", a_out_valid, 0);
      chk("reset_a_out_sum", a_out_sum, 0);
      chk("reset_a_out_ovf", a_out_ovf, 0);
      chk("reset_b_out_valid", b_out_valid, 0);
      @(posedge clk); #1;

      // Maximum operands with carry-in, latency measured from acceptance.
      clear_logs();
      send(all_ops(16'hFFFF), 1'b1, 1'b0, 1'b0);
      idle();
      lat = 0; got = 1'b0;
      for (int n = 0; n < 20 && !got; n++) begin
         @(negedge clk); lat++; got = a_out_valid;
      end
      chk("max_latency", lat, 4);
      chk("max_sum_literal", a_out_sum, 27'h7FFF9);
      chk("max_ovf_literal", a_out_ovf, 0);
      @(posedge clk); #1;
      drain(100);

      // Streaming 20 back-to-back beats.
      clear_logs();
      for (int b = 0; b < 20; b++) send(ramp_ops(b), 1'b0, 1'b0, 1'b0);
      idle();
      drain(100);
      chk("stream_count", log_a.size(), 20);
      for (int b = 0; b < 20 && b < log_a.size(); b++) begin
         chk("stream_literal", log_a[b], 8*b + 28);
         chk("stream_spacing", log_a_cyc[b] - log_a_cyc[0], b);
      end

      // Backpressure: consumer stalls 6 cycles mid-stream.
      clear_logs();
      saw_stall = 1'b0;
      fork
         begin
            for (int b = 0; b < 16; b++) send(rand_ops(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            idle();
         end
         begin
            tick(5); out_ready = 1'b0; tick(6); out_ready = 1'b1;
         end
      join
      drain(200);
      chk("bp_in_ready_dropped", saw_stall, 1);
      chk("bp_count", log_a.size(), 16);

      // Accumulation with an interleaved plain beat.
      clear_logs();
      send(all_ops(16'd1), 1'b0, 1'b1, 1'b0);
      send(all_ops(16'd2), 1'b0, 1'b0, 1'b0);
      send(all_ops(16'd1), 1'b0, 1'b1, 1'b0);
      send(all_ops(16'd1), 1'b0, 1'b1, 1'b1);
      idle();
      drain(100);
      chk("acc_count", log_a.size(), 2);
      if (log_a.size() == 2) begin
         chk("acc_plain_literal", log_a[0], 16);
         chk("acc_total_literal", log_a[1], 24);
      end

      // Overflow on the narrow instance, then a clean single-beat accumulation.
      clear_logs();
      send(all_ops(16'hFFFF), 1'b0, 1'b1, 1'b0);
      send(all_ops(16'hFFFF), 1'b0, 1'b1, 1'b0);
      send(all_ops(16'hFFFF), 1'b0, 1'b1, 1'b1);
      send(all_ops(16'h0000), 1'b0, 1'b1, 1'b1);
      idle();
      drain(100);
      chk("ovf_count", log_b.size(), 2);
      if (log_b.size() == 2 && log_a.size() == 2) begin
         chk("ovf_b_sum_literal", log_b[0], 20'h7FFE8);
         chk("ovf_b_flag_literal", log_b_ovf[0], 1);
         chk("ovf_b_next_sum", log_b[1], 0);
         chk("ovf_b_next_flag", log_b_ovf[1], 0);
         chk("ovf_a_wide_literal", log_a[0], 27'h17FFE8);
      end

      // Reset with a partial accumulation and three plain beats in flight.
      clear_logs();
      send(all_ops(16'd5), 1'b0, 1'b1, 1'b0);
      send(all_ops(16'd3), 1'b0, 1'b0, 1'b0);
      send(all_ops(16'd3), 1'b0, 1'b0, 1'b0);
      send(all_ops(16'd3), 1'b0, 1'b0, 1'b0);
      idle();
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(8);
      chk("rst_no_result", log_a.size() + log_b.size(), 0);
      send(all_ops(16'd1), 1'b0, 1'b1, 1'b1);
      idle();
      drain(100);
      chk("rst_fresh_count", log_a.size(), 1);
      if (log_a.size() == 1) chk("rst_fresh_literal", log_a[0], 8);

      // Randomised traffic with random gaps and consumer stalls.
      rdone = 1'b0;
      fork
         begin
            for (int b = 0; b < 300; b++) begin
               idle();
               tick($urandom_range(0, 2));
               send(rand_ops(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) == 0));
            end
            idle();
            rdone = 1'b1;
         end
         begin
            while (!rdone) begin
               out_ready = ($urandom_range(0, 3) != 0);
               tick(1);
            end
            out_ready = 1'b1;
         end
      join
      drain(2000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/btree_adder_pipe.md
Name: btree_adder_pipe

Overview:
- Parametrised, fully pipelined multi-operand binary-tree adder. Sums N_OPS operands of W bits per beat, with one register stage per tree level.
- Next-generation replacement for the fixed 8/16/32-operand tree adders.
- Adds four things the fixed versions lack: valid/ready backpressure, a single correctly-weighted carry-in, an optional multi-beat accumulate mode, and overflow detection.
- Sits between operand producers (MAC/filter datapaths) and result consumers.

Parameters:
- N_OPS, 8, operand count per beat; power of 2, ≥2.
- W, 16, operand width in bits.
- ACC_W, 8, extra accumulator headroom bits beyond the tree result.
- LEVELS, $clog2(N_OPS), tree depth; derived, not overridable.
- OUT_W, W+LEVELS+ACC_W, output width; derived.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  beat present on inputs
- in_ready  out  1  block accepts the beat this cycle
- in_ops  in  N_OPS*W  operands, unsigned; operand i = in_ops[i*W +: W]
- in_cin  in  1  carry-in, added exactly once per beat
- in_acc  in  1  beat belongs to an accumulation
- in_last  in  1  final beat of an accumulation (ignored when in_acc=0)
- out_valid  out  1  result present
- out_ready  in  1  consumer takes the result
- out_sum  out  OUT_W  result, zero-extended
- out_ovf  out  1  accumulation exceeded OUT_W bits (sticky per accumulation)

Behaviour:
- Reset (rst=1 at posedge):
  - All stage valids, accumulator, acc_active, ovf_sticky, out_valid, out_sum and out_ovf clear to 0.
  - in_ready reads 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight beats and any partial accumulation.
- Tree stages k=1..LEVELS:
  - Stage k registers N_OPS/2^k sums, each W+k bits wide, of pairs from stage k-1 (stage 0 = in_ops).
  - in_cin enters only the lowest adder of stage 1.
  - in_acc and in_last travel with the beat as sideband.
- Handshake:
  - Per-stage ready: ready_k = !v_k || ready_{k+1}.
  - in_ready = ready_1. A beat transfers on in_valid && in_ready.
  - Bubbles collapse, so there is no throughput loss while the consumer is ready.
  - out_sum/out_valid hold stable while out_valid && !out_ready.
- Output stage, taking the tree's final sum T:
  - It advances when the tree's final stage is valid and (!out_valid || out_ready).
  - in_acc=0: out_sum <= T and out_ovf <= 0, out_valid <= 1. Accumulator state is untouched.
  - in_acc=1, in_last=0: acc <= acc + T, modulo 2^OUT_W, and acc_active <= 1. ovf_sticky is set on carry-out. No output is produced; out_valid drops to 0 if the previous result was taken.
  - in_acc=1, in_last=1: out_sum <= acc + T and out_ovf <= ovf_sticky | carry-out. out_valid <= 1. acc, acc_active and ovf_sticky clear.
  - A single-beat accumulation (first beat has in_last=1) returns T.
- Latency and throughput:
  - Latency from accept to out_valid is LEVELS+1 cycles with no stalls (4 cycles at N_OPS=8).
  - Throughput is one beat per cycle.
- Width rules:
  - The tree never overflows.
  - Maximum tree result is N_OPS*(2^W−1)+1, which fits in W+LEVELS bits.

Decomposition:
- Shared package btree_pkg holds:
  - the width helper function lvl_w(W,k)=W+k;
  - the OUT_W formula;
  - a localparam for beat sideband packing (acc, last).
- One sub-module, btree_level: one registered level with a generic pair-count and input width, plus its valid/ready logic. It is instantiated LEVELS times via generate.
- Output and accumulate logic lives in the top module.

Test Plan:
- Max operands, no stall: N_OPS=8, W=16, all ops 0xFFFF, cin=1, acc=0 -> out_sum=0x7FFF9 exactly 4 cycles after accept, out_ovf=0.
- Streaming: 20 consecutive beats with ops[i]=beat+i, out_ready=1 -> 20 results in order, one per cycle, each equal to 8·beat+28.
- Backpressure: hold out_ready=0 for 6 cycles mid-stream -> in_ready drops once the pipeline fills. No beat is lost or duplicated, and out_sum stays stable while stalled.
- Accumulate: 3 beats with all ops=1, acc=1, last only on the third -> exactly one result, out_sum=24. An interleaved acc=0 beat (all ops=2) yields 16 and leaves the accumulation intact.
- Overflow: ACC_W=1 (OUT_W=20), 3 accumulate beats of all ops 0xFFFF -> out_sum=0x7FFE8, out_ovf=1. The next accumulation of 1 beat (all ops 0) gives out_sum=0, out_ovf=0.
- Reset mid-flight: assert rst for 1 cycle with 3 beats in flight and a partial accumulation -> no result emerges. A fresh accumulation after reset excludes the old partial sum.
